gpio_input_ctrl: RTL

GPIO_INPUT_CTRL -- requirements
Module: gpio_input_ctrl

---
 rtl/gpio_input_pkg.sv | 43 ++++
 rtl/gpio_debounce.sv | 89 ++++++++
 rtl/gpio_input_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/gpio_input_pkg.sv
// gpio_input_pkg: register map, register-select decode and counter sizing shared by the GPIO input block.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package gpio_input_pkg;

    // Byte offsets of the four registers inside the 16-byte window
    localparam logic [31:0] DATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] MASK_OFS   = 32'h0000_0008;
    localparam logic [31:0] EDGE_OFS   = 32'h0000_000C;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_DATA,
        REG_STATUS,
        REG_MASK,
        REG_EDGE
    } reg_sel_e;

    // Width of a counter that must hold 0 .. cycles-1
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    // Full 32-bit match; anything outside the four words selects nothing
    function automatic reg_sel_e decode_reg(input logic [31:0] addr, input logic [31:0] base);
        reg_sel_e sel;
        sel = REG_NONE;
        if (addr == base + DATA_OFS) begin
            sel = REG_DATA;
        end else if (addr == base + STATUS_OFS) begin
            sel = REG_STATUS;
        end else if (addr == base + MASK_OFS) begin
            sel = REG_MASK;
        end else if (addr == base + EDGE_OFS) begin
            sel = REG_EDGE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one key channel -- 2-flop synchronizer, hold-time filter (GPIO_IN_DEBOUNCE_EN), edge pulses.
// Latency: key_in to stable is 2 cycles, or 2+DEBOUNCE_CYCLES with GPIO_IN_DEBOUNCE_EN defined.
// Backpressure: none; rise/fall are one-cycle pulses asserted on the cycle whose edge changes stable.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic stable,
    output logic rise,
    output logic fall
);
    import gpio_input_pkg::*;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("gpio_debounce: DEBOUNCE_CYCLES must be within 2..65535");
    end

    // sync_q[0] is the metastability catcher, sync_q[1] the first usable copy
    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       sync_lvl;

    // Shift the raw level one stage further each cycle
    always_comb begin
        sync_d = {sync_q[0], key_in};
    end

    // Synchronizer flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_lvl = sync_q[1];

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;
    logic          accept;

    // Count consecutive cycles of disagreement; accept the new level on the last one
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (sync_lvl == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            accept   = 1'b1;
            stable_d = sync_lvl;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter and filtered level; reset drops any partial count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
    assign rise   = accept & sync_lvl;
    assign fall   = accept & ~sync_lvl;
`else
    // Unfiltered: the level is the synchronizer output, and an edge is seen one
    // stage early so the flag can be set on the same clock that moves the level.
    assign stable = sync_lvl;
    assign rise   = sync_q[0] & ~sync_q[1];
    assign fall   = ~sync_q[0] & sync_q[1];
`endif

endmodule

// File: rtl/gpio_input_ctrl.sv
// gpio_input_ctrl: N_CH debounced key inputs behind a 4-register window (DATA/STATUS/MASK/EDGE_SEL) with level irq.
// Latency: key_in to DATA 2+DEBOUNCE_CYCLES cycles (GPIO_IN_DEBOUNCE_EN defined) or 2; irq one cycle after STATUS/MASK.
// Backpressure: none; reads are combinational and side-effect free, writes complete on the We clock edge.
module gpio_input_ctrl #(
    parameter int          N_CH            = 8,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_7f40
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     addr,
    input  logic [31:0]     datain,
    input  logic            We,
    input  logic [N_CH-1:0] key_in,
    output logic [31:0]     dataout,
    output logic            irq
);
    import gpio_input_pkg::*;

    if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
        $error("gpio_input_ctrl: N_CH must be within 1..32");
    end

    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        gpio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .key_in (key_in[gi]),
            .stable (stable[gi]),
            .rise   (rise[gi]),
            .fall   (fall[gi])
        );
    end

    // Only the low N_CH write-data bits have storage behind them
    logic [N_CH-1:0] wr_bits;
    logic            unused_datain;
    assign wr_bits       = datain[N_CH-1:0];
    assign unused_datain = ^datain;

    reg_sel_e rd_sel;
    reg_sel_e wr_sel;

    // Decode the bus address once for both the read mux and the write strobes
    always_comb begin
        rd_sel = decode_reg(addr, BASE_ADDR);
        wr_sel = We ? rd_sel : REG_NONE;
    end

    logic [N_CH-1:0] status_q;
    logic [N_CH-1:0] status_d;
    logic [N_CH-1:0] mask_q;
    logic [N_CH-1:0] mask_d;
    logic [N_CH-1:0] edge_sel_q;
    logic [N_CH-1:0] edge_sel_d;
    logic            irq_q;
    logic            irq_d;
    logic [N_CH-1:0] edge_hit;
    logic [N_CH-1:0] status_clr;

    // Next register state: EDGE_SEL bit 1 picks rising, 0 picks falling; a new
    // edge is OR-ed in after the W1C mask so set beats clear in the same cycle.
    always_comb begin
        edge_hit   = (rise & edge_sel_q) | (fall & ~edge_sel_q);
        status_clr = (wr_sel == REG_STATUS) ? wr_bits : '0;
        status_d   = (status_q & ~status_clr) | edge_hit;
        mask_d     = (wr_sel == REG_MASK) ? wr_bits : mask_q;
        edge_sel_d = (wr_sel == REG_EDGE) ? wr_bits : edge_sel_q;
        irq_d      = |(status_q & mask_q);
    end

    // Register bank and registered interrupt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q   <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            status_q   <= status_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

    logic [N_CH-1:0] rd_val;

    // Read mux, zero-extended; unmapped addresses read zero
    always_comb begin
        rd_val = '0;
        case (rd_sel)
            REG_DATA:   rd_val = stable;
            REG_STATUS: rd_val = status_q;
            REG_MASK:   rd_val = mask_q;
            REG_EDGE:   rd_val = edge_sel_q;
            default:    rd_val = '0;
        endcase
        dataout = 32'(rd_val);
    end

endmodule
